// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths, Booth digit type and window decoder
// Used by booth_enc and booth_ppgen.
package booth_pkg;

  localparam int N   = 11;
  localparam int NPP = (N + 2) / 2;
  localparam int PPW = 13;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  typedef logic [NPP-1:0][PPW-1:0] pp_vec_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_enc.sv
// rtl/booth_enc.sv - one radix-4 Booth partial product from a 3-bit window
// Purely combinational; negation (invert + 1) is folded in here.
module booth_enc
  import booth_pkg::*;
(
  input  logic [2:0]     win_i,
  input  logic [PPW-1:0] a_i,
  output logic [PPW-1:0] pp_o
);

  booth_digit_t   dig;
  logic [PPW-1:0] mag;

  always_comb begin
    dig = booth_decode(win_i);
    mag = '0;
    case (dig)
      POS1, NEG1: mag = a_i;
      POS2, NEG2: mag = {a_i[PPW-2:0], 1'b0};
      default:    mag = '0;
    endcase
    pp_o = ((dig == NEG1) || (dig == NEG2)) ? (~mag + PPW'(1)) : mag;
  end

endmodule

// File: rtl/booth_ppgen.sv
// rtl/booth_ppgen.sv - two-stage pipelined radix-4 Booth partial-product generator
// Optional BOOTH_PPGEN_SKID_EN adds a 1-entry skid ahead of S1 so in_ready is a flop.
module booth_ppgen #(
  parameter int N   = 11,
  parameter int NPP = (N + 2) / 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N-1:0]                        a_i,
  input  logic [N-1:0]                        b_i,
  input  logic                                signed_i,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NPP-1:0][booth_pkg::PPW-1:0] ops_o
);

  localparam int PPW = booth_pkg::PPW;

  logic                    v1_q;
  logic                    v2_q;
  logic [N-1:0]            a1_q;
  logic [N-1:0]            b1_q;
  logic                    sgn1_q;
  logic [NPP-1:0][PPW-1:0] pp2_q;
  logic [NPP-1:0][PPW-1:0] pp_d;

  logic                    s1_load;
  logic                    s2_load;
  logic                    in_fire;
  logic                    src_valid;
  logic [N-1:0]            src_a;
  logic [N-1:0]            src_b;
  logic                    src_sgn;

  assign s2_load = !v2_q || out_ready;
  assign s1_load = !v1_q || s2_load;
  assign in_fire = in_valid && in_ready;

`ifdef BOOTH_PPGEN_SKID_EN
  logic         skid_v_q;
  logic         skid_v_d;
  logic         rdy_q;
  logic [N-1:0] skid_a_q;
  logic [N-1:0] skid_b_q;
  logic         skid_sgn_q;

  assign in_ready  = rdy_q;
  assign src_valid = skid_v_q || in_fire;
  assign src_a     = skid_v_q ? skid_a_q   : a_i;
  assign src_b     = skid_v_q ? skid_b_q   : b_i;
  assign src_sgn   = skid_v_q ? skid_sgn_q : signed_i;

  // in_ready is low whenever the skid is full, so a fill and a drain never coincide.
  always_comb begin
    skid_v_d = skid_v_q;
    if (skid_v_q) begin
      if (s1_load) skid_v_d = 1'b0;
    end else if (in_fire && !s1_load) begin
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v_q   <= 1'b0;
      rdy_q      <= 1'b0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_sgn_q <= 1'b0;
    end else begin
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
      if (in_fire && !s1_load) begin
        skid_a_q   <= a_i;
        skid_b_q   <= b_i;
        skid_sgn_q <= signed_i;
      end
    end
  end
`else
  logic rdy_en_q;

  // Holds in_ready low while in reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign in_ready  = rdy_en_q && s1_load;
  assign src_valid = in_fire;
  assign src_a     = a_i;
  assign src_b     = b_i;
  assign src_sgn   = signed_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      sgn1_q <= 1'b0;
    end else if (s1_load) begin
      v1_q <= src_valid;
      if (src_valid) begin
        a1_q   <= src_a;
        b1_q   <= src_b;
        sgn1_q <= src_sgn;
      end
    end
  end

  logic [PPW-1:0] a_ext;
  logic [N+1:0]   b_win;

  // b_win is the 12-bit extended multiplier with b[-1]=0 appended below bit 0.
  assign a_ext = {{(PPW-N){sgn1_q & a1_q[N-1]}}, a1_q};
  assign b_win = {sgn1_q & b1_q[N-1], b1_q, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_enc
    booth_enc u_enc (
      .win_i (b_win[2*i+2 -: 3]),
      .a_i   (a_ext),
      .pp_o  (pp_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      pp2_q <= '0;
    end else if (s2_load) begin
      v2_q <= v1_q;
      if (v1_q) pp2_q <= pp_d;
    end
  end

  assign out_valid = v2_q;
  assign ops_o     = pp2_q;

endmodule
